// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: issue controller for an RV32F datapath with a fixed latency.
//
// Decodes each offered instruction, checks its FP operands and FP destination
// against a per-register pending-write scoreboard, and issues at most one
// instruction per cycle. An issued instruction is presented to the datapath
// one cycle after acceptance. Its write-back tag comes out PIPELINE_STAGES
// cycles later through a valid/tag shift register. Unsupported opcodes are
// accepted but only raise a one-cycle illegal pulse.
//
// Ports:
//   ck, rst         clock, synchronous active-high reset
//   flush           kills everything in flight and blocks issue this cycle
//   issue_valid     requester offers issue_instr / issue_id
//   issue_ready     combinational accept (no hazard, not in reset or flush)
//   fpu_valid       one-cycle datapath enable with fpu_instr / fpu_id
//   wb_valid        write-back due; wb_id, wb_rd, wb_fp describe it
//   illegal         one-cycle pulse for an accepted unsupported opcode
//   busy            any instruction in flight or fpu_valid high
//   scoreboard      pending-write bit per FP register
module fpu_issue_ctrl #(
    parameter int unsigned NUM_REGS        = 32,
    parameter int unsigned PIPELINE_STAGES = 4,  // legal range 1..16
    parameter int unsigned X_ID_WIDTH      = 4
) (
    input  logic                  ck,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  issue_valid,
    input  logic [31:0]           issue_instr,
    input  logic [X_ID_WIDTH-1:0] issue_id,
    output logic                  issue_ready,
    output logic                  fpu_valid,
    output logic [31:0]           fpu_instr,
    output logic [X_ID_WIDTH-1:0] fpu_id,
    output logic                  wb_valid,
    output logic [X_ID_WIDTH-1:0] wb_id,
    output logic [4:0]            wb_rd,
    output logic                  wb_fp,
    output logic                  illegal,
    output logic                  busy,
    output logic [NUM_REGS-1:0]   scoreboard
);

    localparam logic [6:0] OpFlw    = 7'b0000111;
    localparam logic [6:0] OpFsw    = 7'b0100111;
    localparam logic [6:0] OpFmadd  = 7'b1000011;
    localparam logic [6:0] OpFmsub  = 7'b1000111;
    localparam logic [6:0] OpFnmsub = 7'b1001011;
    localparam logic [6:0] OpFnmadd = 7'b1001111;
    localparam logic [6:0] OpFp     = 7'b1010011;

    // One-hot scoreboard mask for a register index; indices beyond NUM_REGS
    // are not tracked and map to an empty mask.
    function automatic logic [NUM_REGS-1:0] reg_bit(input logic [4:0] idx);
        logic [NUM_REGS-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i < 32 && 5'(i) == idx) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [6:0] opcode;
    logic [4:0] funct5;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rs3;

    assign opcode = issue_instr[6:0];
    assign rd     = issue_instr[11:7];
    assign rs1    = issue_instr[19:15];
    assign rs2    = issue_instr[24:20];
    assign rs3    = issue_instr[31:27];
    assign funct5 = issue_instr[31:27];

    logic legal;
    logic use_rs1;
    logic use_rs2;
    logic use_rs3;
    logic dst_fp;

    always_comb begin
        legal   = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rs3 = 1'b0;
        dst_fp  = 1'b0;
        case (opcode)
            OpFlw: begin
                // Base address is an integer register: no FP source.
                legal  = 1'b1;
                dst_fp = 1'b1;
            end
            OpFsw: begin
                legal   = 1'b1;
                use_rs2 = 1'b1;
            end
            OpFmadd, OpFmsub, OpFnmsub, OpFnmadd: begin
                legal   = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rs3 = 1'b1;
                dst_fp  = 1'b1;
            end
            OpFp: begin
                legal   = 1'b1;
                // Compares, FCVT.W and FMV.X/FCLASS write the integer file.
                dst_fp  = !(funct5 inside {5'b10100, 5'b11000, 5'b11100});
                // FCVT.S.W and FMV.W.X take an integer source.
                use_rs1 = !(funct5 inside {5'b11010, 5'b11110});
                use_rs2 = funct5 inside {5'b00000, 5'b00001, 5'b00010, 5'b00011,
                                         5'b00100, 5'b00101, 5'b10100};
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Hazard detection with write-back bypass
    // ------------------------------------------------------------------
    logic [NUM_REGS-1:0] scoreboard_q;
    logic [NUM_REGS-1:0] scoreboard_d;
    logic [NUM_REGS-1:0] wb_clr_mask;
    logic [NUM_REGS-1:0] sb_visible;
    logic [NUM_REGS-1:0] need_mask;
    logic                hazard;
    logic                accept;

    // The bit retiring this cycle no longer blocks a dependant.
    assign wb_clr_mask = (wb_valid && wb_fp) ? reg_bit(wb_rd) : '0;
    assign sb_visible  = scoreboard_q & ~wb_clr_mask;

    always_comb begin
        need_mask = '0;
        if (use_rs1) need_mask = need_mask | reg_bit(rs1);
        if (use_rs2) need_mask = need_mask | reg_bit(rs2);
        if (use_rs3) need_mask = need_mask | reg_bit(rs3);
        if (dst_fp)  need_mask = need_mask | reg_bit(rd);
    end

    assign hazard      = legal && (|(need_mask & sb_visible));
    assign issue_ready = !rst && !flush && !hazard;
    assign accept      = issue_valid && issue_ready;

    // Set wins over clear so back-to-back writers of one register stay tracked.
    always_comb begin
        scoreboard_d = scoreboard_q & ~wb_clr_mask;
        if (accept && legal && dst_fp) begin
            scoreboard_d = scoreboard_d | reg_bit(rd);
        end
    end

    // ------------------------------------------------------------------
    // Issue register and write-back shift register
    // ------------------------------------------------------------------
    logic                  fpu_valid_q;
    logic [31:0]           fpu_instr_q;
    logic [X_ID_WIDTH-1:0] fpu_id_q;
    logic                  fpu_dst_fp_q;
    logic                  illegal_q;

    logic [PIPELINE_STAGES-1:0] st_valid_q;
    logic [PIPELINE_STAGES-1:0] st_fp_q;
    logic [X_ID_WIDTH-1:0]      st_id_q [PIPELINE_STAGES];
    logic [4:0]                 st_rd_q [PIPELINE_STAGES];

    always_ff @(posedge ck) begin
        if (rst) begin
            fpu_valid_q  <= 1'b0;
            fpu_instr_q  <= '0;
            fpu_id_q     <= '0;
            fpu_dst_fp_q <= 1'b0;
            illegal_q    <= 1'b0;
            scoreboard_q <= '0;
            st_valid_q   <= '0;
            st_fp_q      <= '0;
            for (int i = 0; i < PIPELINE_STAGES; i++) begin
                st_id_q[i] <= '0;
                st_rd_q[i] <= '0;
            end
        end else begin
            // accept is already low during flush, so these self-clear.
            fpu_valid_q <= accept && legal;
            illegal_q   <= accept && !legal;
            if (accept && legal) begin
                fpu_instr_q  <= issue_instr;
                fpu_id_q     <= issue_id;
                fpu_dst_fp_q <= dst_fp;
            end

            scoreboard_q <= flush ? '0 : scoreboard_d;

            // Tags shift unconditionally; only the valids matter after a flush.
            st_valid_q[0] <= fpu_valid_q && !flush;
            st_fp_q[0]    <= fpu_dst_fp_q;
            st_id_q[0]    <= fpu_id_q;
            st_rd_q[0]    <= fpu_instr_q[11:7];
            for (int i = 1; i < PIPELINE_STAGES; i++) begin
                st_valid_q[i] <= st_valid_q[i-1] && !flush;
                st_fp_q[i]    <= st_fp_q[i-1];
                st_id_q[i]    <= st_id_q[i-1];
                st_rd_q[i]    <= st_rd_q[i-1];
            end
        end
    end

    assign fpu_valid  = fpu_valid_q;
    assign fpu_instr  = fpu_instr_q;
    assign fpu_id     = fpu_id_q;
    assign illegal    = illegal_q;
    assign scoreboard = scoreboard_q;

    assign wb_valid = st_valid_q[PIPELINE_STAGES-1];
    assign wb_fp    = st_fp_q[PIPELINE_STAGES-1];
    assign wb_id    = st_id_q[PIPELINE_STAGES-1];
    assign wb_rd    = st_rd_q[PIPELINE_STAGES-1];

    assign busy = fpu_valid_q || (|st_valid_q);

endmodule

// File: doc/fpu_issue_ctrl.md
FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 The module SHALL have parameter NUM_REGS, default 32: number of FP registers tracked by the scoreboard.
REQ-002 The module SHALL have parameter PIPELINE_STAGES, default 4: fixed FPU datapath latency in cycles, legal range 1..16.
REQ-003 The module SHALL have parameter X_ID_WIDTH, default 4: instruction id width.
REQ-004 ck  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 flush  input  1  kill all in-flight instructions.
REQ-007 issue_valid  input  1  requester offers an instruction.
REQ-008 issue_instr  input  32  RV32F instruction word.
REQ-009 issue_id  input  X_ID_WIDTH  requester id.
REQ-010 issue_ready  output  1  instruction accepted this cycle when high with issue_valid.
REQ-011 fpu_valid  output  1  datapath enable, one cycle per issued instruction.
REQ-012 fpu_instr / fpu_id  output  32 / X_ID_WIDTH  registered instruction and id to datapath.
REQ-013 wb_valid  output  1  result of an issued instruction is due this cycle.
REQ-014 wb_id / wb_rd / wb_fp  output  X_ID_WIDTH / 5 / 1  id, destination index, 1 = FP-register destination.
REQ-015 illegal  output  1  one-cycle pulse: accepted instruction had an unsupported opcode.
REQ-016 busy  output  1  high while any instruction is in flight or fpu_valid is high.
REQ-017 scoreboard  output  NUM_REGS  pending-write bit per FP register.

Function
REQ-018 Decode SHALL use rd=[11:7], rs1=[19:15], rs2=[24:20], rs3=[31:27], opcode=[6:0], funct5=[31:27].
REQ-019 FLW (0000111) SHALL write FP rd and read no FP source; FSW (0100111) SHALL read FP rs2 and write nothing.
REQ-020 FMADD/FMSUB/FNMSUB/FNMADD (1000011/1000111/1001011/1001111) SHALL read FP rs1,rs2,rs3 and write FP rd.
REQ-021 OP-FP (1010011) SHALL write integer rd for funct5 10100/11000/11100, otherwise FP rd; SHALL read FP rs1 except funct5 11010/11110; SHALL read FP rs2 only for funct5 00000/00001/00010/00011/00100/00101/10100.
REQ-022 Hazard SHALL be true when any FP source or the FP destination has its scoreboard bit set, after masking the bit being cleared by wb_valid the same cycle (write-back bypass).
REQ-023 issue_ready SHALL be combinational: !rst && !flush && !hazard; illegal opcodes have no hazard.
REQ-024 On acceptance at edge T: fpu_valid, fpu_instr and fpu_id SHALL be valid in cycle T+1; illegal opcodes SHALL instead pulse illegal in T+1 and never assert fpu_valid or wb_valid.
REQ-025 wb_valid, wb_id, wb_rd and wb_fp SHALL assert exactly PIPELINE_STAGES cycles after the matching fpu_valid cycle, via a PIPELINE_STAGES-deep valid/tag shift register.
REQ-026 At most one issue per cycle; back-to-back accepts SHALL yield back-to-back wb_valid in order.
REQ-027 Scoreboard bit rd SHALL set on acceptance of an FP-destination instruction and clear on the edge ending its wb_valid cycle; simultaneous set and clear of the same bit SHALL leave it set.
REQ-028 flush SHALL clear the shift register, scoreboard, fpu_valid and illegal at the next edge; no wb_valid for flushed instructions; issue blocked in the flush cycle.
REQ-029 The requester SHALL hold issue_valid, issue_instr and issue_id stable until accepted; the block SHALL NOT accept without issue_valid.

Reset
REQ-030 While rst is high at an edge: scoreboard=0, shift register empty, fpu_valid=0, wb_valid=0, illegal=0, busy=0, fpu_instr=0, fpu_id=0, wb_id=0, wb_rd=0, wb_fp=0; rst mid-operation SHALL discard all in-flight work with no write-back.

Verification
REQ-031 FADD.S f3,f1,f2 accepted at T, PIPELINE_STAGES=4 -> fpu_valid at T+1, wb_valid wb_rd=3 wb_fp=1 at T+5, scoreboard[3] high T+1..T+5, low T+6.
REQ-032 FADD f3 at T, then FMUL f4,f3,f5 held valid -> issue_ready low until the wb_valid cycle of f3 (bypass), accepted that cycle, its wb_valid 5 cycles later.
REQ-033 Four independent FADDs (rd 1..4) on consecutive cycles -> four consecutive fpu_valid and wb_valid pulses, ids in order, busy high throughout.
REQ-034 FLT.S x5,f1,f2 -> wb_fp=0, scoreboard unchanged; opcode 0110011 -> illegal pulse, no fpu_valid, no wb_valid.
REQ-035 Two instructions in flight, flush asserted one cycle -> scoreboard=0 and busy=0 next cycle, no wb_valid for either; rst asserted mid-flight -> identical.
